// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 16-bit pipeline.
//   Forwards rs1/rs2/rd operands from the EX/MEM and MEM/WB producers,
//   evaluates the 3-bit ALU op, and runs a 16-step shift-add multiplier for MUL.
// Ports:
//   CLK, Reset             - rising-edge clock, synchronous active-high reset
//   I*                     - ID/EX pipeline register contents
//   FwdMem*, FwdWb*        - EX/MEM and MEM/WB writeback producers
//   Stall                  - holds ID/EX while a multiply is in progress
//   O*                     - EX/MEM pipeline register inputs; OValid=0 is a bubble
module ex_stage (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        IRegWrite,
  input  logic        IMemWrite,
  input  logic        IMemRead,
  input  logic        IALUSrc,
  input  logic [2:0]  IALUOP,
  input  logic [1:0]  IRegStore,
  input  logic [15:0] IPCP2,
  input  logic [15:0] I1stArg,
  input  logic [15:0] I2ndArg,
  input  logic [15:0] I3rdArg,
  input  logic [15:0] IImm,
  input  logic [2:0]  IRs1,
  input  logic [2:0]  IRs2,
  input  logic [2:0]  IRd,
  input  logic        FwdMemRegWrite,
  input  logic [2:0]  FwdMemRd,
  input  logic [15:0] FwdMemData,
  input  logic        FwdWbRegWrite,
  input  logic [2:0]  FwdWbRd,
  input  logic [15:0] FwdWbData,
  output logic        Stall,
  output logic        ORegWrite,
  output logic        OMemWrite,
  output logic        OMemRead,
  output logic        OValid,
  output logic [1:0]  ORegStore,
  output logic [15:0] OPCP2,
  output logic [2:0]  ORd,
  output logic [15:0] OResult,
  output logic [15:0] OStoreData,
  output logic        OZero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state;
  logic [15:0] acc;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [3:0]  count;

  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] fwd_rs2;
  logic [15:0] alu_res;
  logic        is_mul;

  // EX/MEM has priority over MEM/WB; register 0 is never forwarded.
  function automatic logic [15:0] fwd(input logic [15:0] val, input logic [2:0] idx,
                                      input logic mem_we, input logic [2:0] mem_rd,
                                      input logic [15:0] mem_data,
                                      input logic wb_we, input logic [2:0] wb_rd,
                                      input logic [15:0] wb_data);
    if (idx != 3'd0 && mem_we && mem_rd == idx)
      return mem_data;
    else if (idx != 3'd0 && wb_we && wb_rd == idx)
      return wb_data;
    else
      return val;
  endfunction

  always_comb begin
    op_a       = fwd(I1stArg, IRs1, FwdMemRegWrite, FwdMemRd, FwdMemData,
                     FwdWbRegWrite, FwdWbRd, FwdWbData);
    fwd_rs2    = fwd(I2ndArg, IRs2, FwdMemRegWrite, FwdMemRd, FwdMemData,
                     FwdWbRegWrite, FwdWbRd, FwdWbData);
    OStoreData = fwd(I3rdArg, IRd, FwdMemRegWrite, FwdMemRd, FwdMemData,
                     FwdWbRegWrite, FwdWbRd, FwdWbData);
    op_b       = IALUSrc ? IImm : fwd_rs2;
  end

  always_comb begin
    alu_res = '0;
    case (IALUOP)
      3'd0: alu_res = op_a + op_b;
      3'd1: alu_res = op_a - op_b;
      3'd2: alu_res = op_a & op_b;
      3'd3: alu_res = op_a | op_b;
      3'd4: alu_res = op_a ^ op_b;
      3'd5: alu_res = ($signed(op_a) < $signed(op_b)) ? 16'd1 : 16'd0;
      3'd6: alu_res = op_a << op_b[3:0];
      default: alu_res = '0;
    endcase
  end

  assign is_mul = (IALUOP == 3'd7);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_mul) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
            count  <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (mplier[0])
            acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 4'd1;
          if (count == 4'd15)
            state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stall is asserted in the issue cycle (IDLE with MUL) and throughout RUN.
  always_comb begin
    Stall  = 1'b0;
    OValid = 1'b0;
    if (!Reset) begin
      case (state)
        S_IDLE: begin
          Stall  = is_mul;
          OValid = !is_mul;
        end
        S_RUN: begin
          Stall  = 1'b1;
          OValid = 1'b0;
        end
        S_DONE: begin
          Stall  = 1'b0;
          OValid = 1'b1;
        end
        default: begin
          Stall  = 1'b0;
          OValid = 1'b0;
        end
      endcase
    end
  end

  assign OResult   = (state == S_DONE) ? acc : alu_res;
  assign OZero     = (OResult == '0);
  assign ORegWrite = IRegWrite & OValid;
  assign OMemWrite = IMemWrite & OValid;
  assign OMemRead  = IMemRead & OValid;
  assign ORegStore = IRegStore;
  assign OPCP2     = IPCP2;
  assign ORd       = IRd;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic        CLK;
  logic        Reset;
  logic        IRegWrite, IMemWrite, IMemRead, IALUSrc;
  logic [2:0]  IALUOP;
  logic [1:0]  IRegStore;
  logic [15:0] IPCP2, I1stArg, I2ndArg, I3rdArg, IImm;
  logic [2:0]  IRs1, IRs2, IRd;
  logic        FwdMemRegWrite;
  logic [2:0]  FwdMemRd;
  logic [15:0] FwdMemData;
  logic        FwdWbRegWrite;
  logic [2:0]  FwdWbRd;
  logic [15:0] FwdWbData;
  logic        Stall, ORegWrite, OMemWrite, OMemRead, OValid, OZero;
  logic [1:0]  ORegStore;
  logic [15:0] OPCP2, OResult, OStoreData;
  logic [2:0]  ORd;

  int n_checks = 0;
  int n_fail   = 0;

  ex_stage dut (
    .CLK(CLK), .Reset(Reset),
    .IRegWrite(IRegWrite), .IMemWrite(IMemWrite), .IMemRead(IMemRead),
    .IALUSrc(IALUSrc), .IALUOP(IALUOP), .IRegStore(IRegStore), .IPCP2(IPCP2),
    .I1stArg(I1stArg), .I2ndArg(I2ndArg), .I3rdArg(I3rdArg), .IImm(IImm),
    .IRs1(IRs1), .IRs2(IRs2), .IRd(IRd),
    .FwdMemRegWrite(FwdMemRegWrite), .FwdMemRd(FwdMemRd), .FwdMemData(FwdMemData),
    .FwdWbRegWrite(FwdWbRegWrite), .FwdWbRd(FwdWbRd), .FwdWbData(FwdWbData),
    .Stall(Stall), .ORegWrite(ORegWrite), .OMemWrite(OMemWrite), .OMemRead(OMemRead),
    .OValid(OValid), .ORegStore(ORegStore), .OPCP2(OPCP2), .ORd(ORd),
    .OResult(OResult), .OStoreData(OStoreData), .OZero(OZero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic src, input logic [15:0] imm);
    IALUOP  = op;
    I1stArg = a;
    I2ndArg = b;
    IALUSrc = src;
    IImm    = imm;
    #1;
  endtask

  // Runs one MUL from its issue cycle; returns 1 time unit after the edge ending DONE.
  task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp);
    int stall_cycles;
    stall_cycles = 0;
    set_op(3'd7, a, b, 1'b0, 16'h0000);
    for (int i = 0; i < 17; i++) begin
      check({tag, " stall"}, {15'd0, Stall}, 16'd1);
      check({tag, " bubble"}, {13'd0, OValid, ORegWrite, OMemWrite}, 16'd0);
      if (Stall) stall_cycles++;
      if (i == 2) begin
        // Disturb forwarding mid-multiply; latched operands must not change.
        FwdMemRegWrite = 1'b1; FwdMemRd = 3'd1; FwdMemData = 16'hDEAD;
        FwdWbRegWrite  = 1'b1; FwdWbRd  = 3'd2; FwdWbData  = 16'hBEEF;
      end
      next_cycle();
    end
    check({tag, " stall_cycles"}, 16'(stall_cycles), 16'd17);
    check({tag, " done_stall"}, {15'd0, Stall}, 16'd0);
    check({tag, " done_valid"}, {15'd0, OValid}, 16'd1);
    check({tag, " done_regwrite"}, {15'd0, ORegWrite}, 16'd1);
    check({tag, " result"}, OResult, exp);
    check({tag, " zero"}, {15'd0, OZero}, {15'd0, exp == 16'h0000});
    FwdMemRegWrite = 1'b0; FwdWbRegWrite = 1'b0;
    next_cycle();
  endtask

  initial begin
    Reset = 1'b1;
    IRegWrite = 1'b1; IMemWrite = 1'b1; IMemRead = 1'b1;
    IALUSrc = 1'b0; IALUOP = 3'd7; IRegStore = 2'd2; IPCP2 = 16'h0102;
    I1stArg = '0; I2ndArg = '0; I3rdArg = 16'h3333; IImm = '0;
    IRs1 = 3'd1; IRs2 = 3'd2; IRd = 3'd4;
    FwdMemRegWrite = 1'b0; FwdMemRd = '0; FwdMemData = '0;
    FwdWbRegWrite = 1'b0; FwdWbRd = '0; FwdWbData = '0;

    // Reset holds off MUL stall and all writes.
    next_cycle();
    next_cycle();
    check("rst stall", {15'd0, Stall}, 16'd0);
    check("rst valid", {15'd0, OValid}, 16'd0);
    check("rst wr", {13'd0, ORegWrite, OMemWrite, OMemRead}, 16'd0);
    check("rst pass_pc", OPCP2, 16'h0102);
    check("rst pass_rd", {13'd0, ORd}, 16'd4);
    check("rst pass_store", {14'd0, ORegStore}, 16'd2);

    IALUOP = 3'd0;
    Reset = 1'b0;
    IMemWrite = 1'b0; IMemRead = 1'b0;

    // ADD no hazard.
    set_op(3'd0, 16'h1234, 16'h0F0F, 1'b0, 16'h0000);
    check("add result", OResult, 16'h2143);
    check("add valid", {15'd0, OValid}, 16'd1);
    check("add stall", {15'd0, Stall}, 16'd0);
    check("add regwrite", {15'd0, ORegWrite}, 16'd1);
    check("add storedata", OStoreData, 16'h3333);

    // Forward priority.
    IRs1 = 3'd3; IRd = 3'd3;
    FwdMemRegWrite = 1'b1; FwdMemRd = 3'd3; FwdMemData = 16'h00AA;
    FwdWbRegWrite  = 1'b1; FwdWbRd  = 3'd3; FwdWbData  = 16'h0055;
    set_op(3'd0, 16'h1111, 16'h2222, 1'b1, 16'h0001);
    check("fwd mem_wins", OResult, 16'h00AB);
    check("fwd store_mem", OStoreData, 16'h00AA);
    FwdMemRegWrite = 1'b0;
    #1;
    check("fwd wb_only", OResult, 16'h0056);
    check("fwd store_wb", OStoreData, 16'h0055);
    FwdMemRegWrite = 1'b1;
    IRs1 = 3'd0; FwdMemRd = 3'd0; FwdWbRd = 3'd0;
    #1;
    check("fwd r0", OResult, 16'h1112);
    // rs2 forwarded via MEM/WB when ALUSrc=0.
    IRs2 = 3'd5; FwdWbRd = 3'd5; FwdMemRd = 3'd6;
    set_op(3'd1, 16'h0005, 16'h9999, 1'b0, 16'h0000);
    FwdWbData = 16'h0007;
    #1;
    check("fwd rs2 sub", OResult, 16'hFFFE);
    FwdMemRegWrite = 1'b0; FwdWbRegWrite = 1'b0;
    IRs1 = 3'd1; IRs2 = 3'd2; IRd = 3'd4;

    // Logic ops.
    set_op(3'd2, 16'hF0F0, 16'h3C3C, 1'b0, 16'h0000);
    check("and", OResult, 16'h3030);
    set_op(3'd3, 16'hF0F0, 16'h3C3C, 1'b0, 16'h0000);
    check("or", OResult, 16'hFCFC);
    set_op(3'd4, 16'hF0F0, 16'h3C3C, 1'b0, 16'h0000);
    check("xor", OResult, 16'hCCCC);
    check("xor nonzero", {15'd0, OZero}, 16'd0);
    set_op(3'd4, 16'hA5A5, 16'hA5A5, 1'b0, 16'h0000);
    check("xor zero", {15'd0, OZero}, 16'd1);

    // SLT / SHL edges.
    set_op(3'd5, 16'h8000, 16'h0001, 1'b0, 16'h0000);
    check("slt neg_lt_pos", OResult, 16'h0001);
    set_op(3'd5, 16'h0001, 16'h8000, 1'b0, 16'h0000);
    check("slt pos_lt_neg", OResult, 16'h0000);
    set_op(3'd6, 16'h0001, 16'h0000, 1'b1, 16'h0013);
    check("shl by3", OResult, 16'h0008);
    set_op(3'd6, 16'h1234, 16'h0000, 1'b1, 16'h0010);
    check("shl by0", OResult, 16'h1234);
    next_cycle();

    // MUL with full stall/bubble checks.
    IMemWrite = 1'b1; IMemRead = 1'b1;
    do_mul("mul1", 16'h0123, 16'h0045, 16'h4E6F);
    IMemWrite = 1'b0; IMemRead = 1'b0;

    // Back-to-back MULs then ADD.
    do_mul("mul_ffff", 16'hFFFF, 16'hFFFF, 16'h0001);
    do_mul("mul_ovf", 16'h0100, 16'h0100, 16'h0000);
    set_op(3'd0, 16'h0002, 16'h0003, 1'b0, 16'h0000);
    check("post_mul add", OResult, 16'h0005);
    check("post_mul stall", {15'd0, Stall}, 16'd0);
    check("post_mul valid", {15'd0, OValid}, 16'd1);
    next_cycle();

    // Abort at RUN step 8.
    set_op(3'd7, 16'h7777, 16'h3333, 1'b0, 16'h0000);
    for (int i = 0; i < 9; i++) next_cycle();
    check("abort pre stall", {15'd0, Stall}, 16'd1);
    Reset = 1'b1;
    #1;
    check("abort rst stall", {15'd0, Stall}, 16'd0);
    check("abort rst valid", {15'd0, OValid}, 16'd0);
    next_cycle();
    Reset = 1'b0;
    set_op(3'd0, 16'h0001, 16'h0001, 1'b0, 16'h0000);
    check("abort idle stall", {15'd0, Stall}, 16'd0);
    check("abort idle valid", {15'd0, OValid}, 16'd1);
    check("abort idle result", OResult, 16'h0002);
    next_cycle();
    do_mul("mul_3x5", 16'h0003, 16'h0005, 16'h000F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 16-bit pipeline, sitting between the ID/EX pipeline register and the EX/MEM pipeline register. It forwards operands from the EX/MEM and MEM/WB stages and evaluates the 3-bit ALU operation. It runs a 16-cycle shift-add multiplier for the MUL opcode. During the multiply it holds the ID/EX register through `Stall` and emits bubbles downstream.

## Interface
- No parameters; datapath fixed at 16 bits, register index 3 bits.
- `CLK` in 1: rising-edge clock.
- `Reset` in 1: reset, synchronous, active-high.
- `IRegWrite`, `IMemWrite`, `IMemRead` in 1 each: control bits from ID/EX.
- `IALUSrc` in 1: 1 selects `IImm` as operand B.
- `IALUOP` in 3: ALU operation select.
- `IRegStore` in 2: writeback source select; passed through.
- `IPCP2` in 16: PC+2; passed through.
- `I1stArg`, `I2ndArg` in 16 each: rs1 and rs2 register values.
- `I3rdArg` in 16: store data, indexed by `IRd`.
- `IImm` in 16: sign-extended immediate.
- `IRs1`, `IRs2`, `IRd` in 3 each: register indices.
- `FwdMemRegWrite` in 1, `FwdMemRd` in 3, `FwdMemData` in 16: EX/MEM producer.
- `FwdWbRegWrite` in 1, `FwdWbRd` in 3, `FwdWbData` in 16: MEM/WB producer.
- `Stall` out 1: 1 holds the ID/EX register; ID/EX `RB_write` = !`Stall`.
- `ORegWrite`, `OMemWrite`, `OMemRead` out 1 each: input control bits gated by `OValid`.
- `OValid` out 1: 0 marks a bubble to EX/MEM.
- `ORegStore` out 2, `OPCP2` out 16, `ORd` out 3: pass-through.
- `OResult` out 16: ALU or multiplier result.
- `OStoreData` out 16: forwarded store data.
- `OZero` out 1: 1 when `OResult` == 0.

## Operation
- Forwarding applies per operand to (`I1stArg`,`IRs1`), (`I2ndArg`,`IRs2`) and (`I3rdArg`,`IRd`).
  - An EX/MEM match wins: `FwdMemRegWrite`=1 and `FwdMemRd`==index.
  - Otherwise a MEM/WB match: `FwdWbRegWrite`=1 and `FwdWbRd`==index.
  - Otherwise the register value is used.
  - Index 0 is never forwarded.
- Operands: A = fwd rs1; B = `IImm` if `IALUSrc` else fwd rs2. `OStoreData` = fwd rd value.
- `IALUOP` encodings, all modulo 2^16:
  - 0 ADD; 1 SUB (A−B); 2 AND; 3 OR; 4 XOR.
  - 5 SLT: signed A<B gives 1, else 0.
  - 6 SHL: A << B[3:0].
  - 7 MUL: low 16 bits of A×B, multi-cycle.
- Ops 0–6 are combinational single-cycle: `Stall`=0, `OValid`=1.
- Multiplier FSM has states IDLE, RUN, DONE.
  - IDLE: when `IALUOP`=7, `Stall`=1 and `OValid`=0. At the edge it latches mcand=A and mplier=B, clears acc and count, and moves to RUN.
  - RUN: each edge, if mplier[0] then acc += mcand; then mcand <<= 1, mplier >>= 1, count++. After the 16th step it moves to DONE. `Stall`=1, `OValid`=0 throughout.
  - DONE: `Stall`=0, `OValid`=1, `OResult`=acc. Returns to IDLE at the next edge.
  - A MUL present in ID/EX after DONE starts a new multiply.
- Operands are latched in IDLE. Forwarding changes during RUN (EX/MEM fills with bubbles, MEM/WB drains) do not affect the product.

## Timing
- Reset: FSM returns to IDLE, acc, mcand, mplier and count are cleared.
  - While `Reset`=1: `Stall`=0 and `OValid`=0, so `ORegWrite`, `OMemWrite`, `OMemRead` are 0.
  - `OResult`, `OStoreData` and pass-through outputs follow inputs combinationally; they are don't-care to EX/MEM because ID/EX is reset too.
- Non-MUL latency is 0 cycles; outputs are valid in the same cycle the ID/EX register presents the instruction.
- MUL: issue cycle C0 sees the op in IDLE.
  - `Stall`=1 in cycles C0..C16 (17 cycles); RUN occupies C1..C16.
  - Result is valid with `OValid`=1 in C17, and ID/EX advances at the end of C17.
  - Throughput is one MUL per 18 cycles.
- `Reset` asserted during RUN or DONE aborts the multiply; IDLE holds at the next edge and no partial result is ever emitted with `OValid`=1.
- When EX/MEM and MEM/WB both match the same index, the EX/MEM data is used.
- MUL overflow discards the high product bits; signed and unsigned low halves are identical.
- SHL with B[3:0]=0 returns A; B[15:4] is ignored.

## Test plan
- ADD no hazard: A=0x1234, B=0x0F0F, `IALUSrc`=0 -> same cycle `OResult`=0x2143, `OValid`=1, `Stall`=0.
- Forward priority: `IRs1`=3 with `FwdMemRd`=3 (0x00AA) and `FwdWbRd`=3 (0x0055), both write-enabled, ADD with `IImm`=1, `IALUSrc`=1 -> `OResult`=0x00AB. Repeat with `IRs1`=0 -> `I1stArg`+1.
- MUL: A=0x0123, B=0x0045 -> `Stall`=1 for exactly 17 cycles with `OValid`=0 and all write/mem outputs 0; then one cycle with `OResult`=0x4E6F, `OValid`=1, `Stall`=0.
- Back-to-back MUL then ADD: 0xFFFF×0xFFFF -> 0x0001 after 18 cycles. A second MUL, 0x0100×0x0100 -> 0x0000 with `OZero`=1, starts the cycle after DONE. A following ADD completes with no stall.
- Reset at RUN step 8 -> next cycle IDLE, `Stall`=0, `OValid`=0. After release, a fresh MUL 3×5 -> 0x000F, not a mixed value.
- SLT/SHL edges: SLT 0x8000 vs 0x0001 -> 1. SLT 0x0001 vs 0x8000 -> 0. SHL 0x0001 by B=0x0013 -> 0x0008.
